// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between core
// writeback (highest priority, zero latency) and a buffered secondary unit.
// Secondary results wait in a small FIFO, and their destinations act as a
// scoreboard for read hazards. A starvation counter forces a one-cycle core
// stall so that the FIFO always makes progress.
//
// Handshake: a secondary result transfers at the posedge where
// sec_valid && sec_ready. sec_ready is decoded from the registered count
// only, so a pop in the same cycle never frees a slot early. Results
// addressed to x0 are accepted and dropped.
module regfile_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int XLEN     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       core_we,
  input  logic [4:0]                 core_rd,
  input  logic [XLEN-1:0]            core_wdata,
  input  logic                       sec_valid,
  output logic                       sec_ready,
  input  logic [4:0]                 sec_rd,
  input  logic [XLEN-1:0]            sec_wdata,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  output logic                       hazard,
  output logic                       stall_core,
  output logic                       rf_we,
  output logic [4:0]                 rf_addr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic empty;
  logic ce;
  logic head_live;
  logic pop;
  logic push;

  assign empty      = (count_q == '0);
  assign sec_ready  = (count_q < FULL_CNT);
  assign stall_core = (wait_q == WAIT_MAX) && !empty;
  assign fifo_count = count_q;
  assign push       = sec_valid && sec_ready && (sec_rd != 5'd0);

  // Slot selection: core write wins unless a forced drain is due; a dead
  // head is popped silently even while the core owns the port.
  always_comb begin
    ce        = core_we && (core_rd != 5'd0) && !stall_core;
    head_live = live_q[rd_ptr_q];
    pop       = 1'b0;
    rf_we     = 1'b0;
    rf_addr   = 5'd0;
    rf_wdata  = '0;
    if (ce) begin
      rf_we    = 1'b1;
      rf_addr  = core_rd;
      rf_wdata = core_wdata;
      pop      = !empty && !head_live;
    end else if (!empty) begin
      pop      = 1'b1;
      rf_we    = head_live;
      rf_addr  = rd_mem_q[rd_ptr_q];
      rf_wdata = data_mem_q[rd_ptr_q];
    end
  end

  // Read hazard: any stored live entry targeting a nonzero source register.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (((rd_mem_q[i] == rs1) && (rs1 != 5'd0)) ||
                        ((rd_mem_q[i] == rs2) && (rs2 != 5'd0)))) begin
        hazard = 1'b1;
      end
    end
  end

  // Next-state for pointers, occupancy, live bits and the starvation counter.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    live_d   = live_q;
    // Older entries overwritten by a core write must not land later.
    for (int i = 0; i < DEPTH; i++) begin
      if (ce && live_q[i] && (rd_mem_q[i] == core_rd)) begin
        live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
    end
    // The incoming entry is younger than the core write and stays live.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
    end
    if (pop || empty) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      live_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      live_q   <= live_d;
    end
  end

  // Entry payload storage; validity is carried entirely by live_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= sec_rd;
      data_mem_q[wr_ptr_q] <= sec_wdata;
    end
  end

endmodule
